// File: rtl/cofi_coeff_ctrl.sv
// Picks the composite-blend IIR coefficient from measured line period and blend mode; generates the filter-enable strobe.
// Outputs are registered (1 clk latency); coefficient commits only on vblank rise; no backpressure.
module cofi_coeff_ctrl #(
    parameter int CNT_W = 14,
    parameter int TH0   = 1429,
    parameter int TH1   = 2095,
    parameter int TH2   = 2857,
    parameter int TH3   = 4572
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       hblank,
    input  logic       vblank,
    input  logic [1:0] mode,
    input  logic       scandoubler_disable,
    output logic [3:0] coefficient,
    output logic       trigger,
    output logic       cfg_valid
);

    typedef enum logic {S_IDLE, S_COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TH0_C   = CNT_W'(TH0);
    localparam logic [CNT_W-1:0] TH1_C   = CNT_W'(TH1);
    localparam logic [CNT_W-1:0] TH2_C   = CNT_W'(TH2);
    localparam logic [CNT_W-1:0] TH3_C   = CNT_W'(TH3);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] counter_q, counter_d;
    logic             last_valid_q, last_valid_d;
    logic [2:0]       last_bin_q, last_bin_d;
    logic             stable_q, stable_d;
    logic [2:0]       pending_bin_q, pending_bin_d;
    logic [3:0]       coefficient_q, coefficient_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic             trigger_q, trigger_d;
    logic             hblank_q, hblank_d;
    logic             vblank_q, vblank_d;

    logic       hb_fall;
    logic       vb_rise;
    logic [2:0] meas_bin;
    logic [3:0] table_coef;

    always_comb begin
        meas_bin = 3'd4;
        if (counter_q < TH0_C)      meas_bin = 3'd0;
        else if (counter_q < TH1_C) meas_bin = 3'd1;
        else if (counter_q < TH2_C) meas_bin = 3'd2;
        else if (counter_q < TH3_C) meas_bin = 3'd3;
    end

    // mode[1] separates strong (2) from soft (1); only those two modes reach the table.
    always_comb begin
        table_coef = 4'd0;
        case (pending_bin_q)
            3'd0:    table_coef = mode[1] ? 4'd7 : 4'd10;
            3'd1:    table_coef = mode[1] ? 4'd7 : 4'd9;
            3'd2:    table_coef = mode[1] ? 4'd4 : 4'd6;
            3'd3:    table_coef = mode[1] ? 4'd4 : 4'd5;
            default: table_coef = mode[1] ? 4'd2 : 4'd3;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        counter_d     = counter_q;
        last_valid_d  = last_valid_q;
        last_bin_d    = last_bin_q;
        stable_d      = stable_q;
        pending_bin_d = pending_bin_q;
        coefficient_d = coefficient_q;
        cfg_valid_d   = cfg_valid_q;
        hblank_d      = hblank;
        vblank_d      = vblank;
        hb_fall       = hblank_q & ~hblank;
        vb_rise       = ~vblank_q & vblank;
        trigger_d     = ~trigger_q | hblank | ~scandoubler_disable;

        case (state_q)
            S_IDLE: begin
                if (hb_fall) begin
                    counter_d = CNT_ONE;
                    state_d   = S_COUNT;
                end
            end
            default: begin
                if (hb_fall) begin
                    stable_d     = last_valid_q && (meas_bin == last_bin_q);
                    if (stable_d) pending_bin_d = meas_bin;
                    last_bin_d   = meas_bin;
                    last_valid_d = 1'b1;
                    counter_d    = CNT_ONE;
                end else if (counter_q == CNT_MAX) begin
                    // No hblank activity: line timing lost, restart measurement.
                    state_d      = S_IDLE;
                    last_valid_d = 1'b0;
                    stable_d     = 1'b0;
                end else begin
                    counter_d = counter_q + CNT_ONE;
                end
            end
        endcase

        // Commit reads the pre-update stable/pending so a coincident line edge cannot leak in.
        if (vb_rise) begin
            if (stable_q && (mode == 2'd1 || mode == 2'd2)) begin
                coefficient_d = table_coef;
                cfg_valid_d   = 1'b1;
            end else begin
                coefficient_d = 4'd0;
                cfg_valid_d   = stable_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            counter_q     <= '0;
            last_valid_q  <= 1'b0;
            last_bin_q    <= 3'd0;
            stable_q      <= 1'b0;
            pending_bin_q <= 3'd0;
            coefficient_q <= 4'd0;
            cfg_valid_q   <= 1'b0;
            trigger_q     <= 1'b1;
            hblank_q      <= 1'b1;
            vblank_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            counter_q     <= counter_d;
            last_valid_q  <= last_valid_d;
            last_bin_q    <= last_bin_d;
            stable_q      <= stable_d;
            pending_bin_q <= pending_bin_d;
            coefficient_q <= coefficient_d;
            cfg_valid_q   <= cfg_valid_d;
            trigger_q     <= trigger_d;
            hblank_q      <= hblank_d;
            vblank_q      <= vblank_d;
        end
    end

    assign coefficient = coefficient_q;
    assign cfg_valid   = cfg_valid_q;
    assign trigger     = trigger_q;

endmodule

// File: doc/cofi_coeff_ctrl.md
Name: cofi_coeff_ctrl

Overview:
- Configuration controller for the composite-blend IIR filter bank (three per-channel IIR filters sharing one 4-bit coefficient and one enable strobe).
- Measures the video-chain clock period in clocks per line. Combines that with a user blend-strength select to pick the coefficient.
- Commits coefficient changes only at the vblank rising edge, so a frame is never filtered with mixed settings.
- Generates the filter-enable strobe that gives half-rate filtering when the scandoubler is disabled.

Parameters:
- CNT_W, 14, width of the line-period counter; saturation value is 2^CNT_W-1 (16383).
- TH0, 1429, line-clock upper bound (exclusive) of bin 0 (~21 MHz chain).
- TH1, 2095, upper bound of bin 1 (~24 MHz).
- TH2, 2857, upper bound of bin 2 (~42 MHz).
- TH3, 4572, upper bound of bin 3 (~48 MHz); counts >= TH3 fall in bin 4 (~96 MHz).

Ports:
- clk  in  1  video-chain clock
- reset  in  1  synchronous, active-high reset
- hblank  in  1  horizontal blank from the video source
- vblank  in  1  vertical blank from the video source
- mode  in  2  0=off, 1=soft (3 MHz cutoff), 2=strong (2 MHz cutoff), 3=off
- scandoubler_disable  in  1  1 = native 15 kHz output, so the filter runs at half rate
- coefficient  out  4  filter coefficient; 0 bypasses the filters
- trigger  out  1  filter enable strobe
- cfg_valid  out  1  1 = coefficient derived from a stable measurement

Behaviour:
- Reset (sync, active-high, clk domain):
  - coefficient=0, cfg_valid=0, trigger=1.
  - state=S_IDLE; counter=0; last_valid=0; stable=0; pending_bin=0.
  - hblank_d=1 and vblank_d=1, so no false edge is seen on the first cycle after reset.
- Edge detect from registered copies:
  - hb_fall = hblank_d & !hblank.
  - vb_rise = !vblank_d & vblank.
- S_IDLE: on hb_fall, set counter=1 and go to S_COUNT.
- S_COUNT:
  - counter increments by 1 every clk.
  - On hb_fall, compute bin from the current counter value:
    - <TH0 -> 0; <TH1 -> 1; <TH2 -> 2; <TH3 -> 3; else 4.
    - stable <= last_valid & (bin==last_bin); if stable becomes 1, pending_bin <= bin.
    - last_bin <= bin; last_valid <= 1; counter <= 1; stay in S_COUNT.
  - If counter reaches 2^CNT_W-1 without hb_fall (no line timing), go to S_IDLE and clear last_valid and stable. pending_bin is kept.
- Coefficient table, indexed by pending_bin 0..4:
  - mode 1: 10, 9, 6, 5, 3.
  - mode 2: 7, 7, 4, 4, 2.
- Commit, on vb_rise only:
  - If stable and mode is 1 or 2: coefficient <= table value; cfg_valid <= 1.
  - Otherwise: coefficient <= 0; cfg_valid <= stable.
  - Between vb_rise events both outputs hold, regardless of mode, scandoubler_disable or measurement changes.
- Simultaneous hb_fall and vb_rise: the commit uses the stable/pending_bin values registered before this cycle's measurement update.
- Trigger, registered, 1-cycle latency: trigger <= !trigger | hblank | !scandoubler_disable.
  - Held high while scandoubler_disable=0.
  - Held high during hblank.
  - Toggles in active video when scandoubler_disable=1; phase realigns at the end of each hblank (first active cycle is 1, then 0, 1, ...).
- Reset mid-frame: all outputs return to reset values on the next clk edge; the measurement restarts from S_IDLE.

Test Plan:
- Reset, then lines of 2667 clks (hblank low 2200, high 467), mode=1, vblank pulse after line 3 -> coefficient=6, cfg_valid=1 on the cycle after the vblank rising edge; both 0 before it.
- Same timing, mode=2 -> coefficient=4. Switch mode to 1 mid-frame -> coefficient stays 4 until the next vb_rise, then becomes 6.
- Alternating line lengths 1333 and 3048 -> stable never sets; at vb_rise coefficient=0 and cfg_valid=0.
- Hold hblank low for 20000 clks -> FSM returns to S_IDLE at counter 16383. After normal lines resume, two lines are needed before stable=1.
- scandoubler_disable=1 -> trigger is 1,0,1,0 in active video, 1 throughout hblank, and restarts at 1 after the hblank fall. scandoubler_disable=0 -> trigger is constant 1.
- Boundaries: line length 1428 gives bin 0 (mode 1 -> 10); 1429 gives bin 1 (-> 9). hb_fall coinciding with vb_rise on the second equal line -> commit gives coefficient=0 and cfg_valid=0 (old stable); the next frame commits the table value.
